// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_pkg;

    // Memory control word: bit 1 requests a read, bit 0 requests a write.
    typedef logic [1:0] mem_ctrl_t;

    localparam int unsigned MEM_RD_BIT = 1;
    localparam int unsigned MEM_WR_BIT = 0;
    localparam mem_ctrl_t   MEM_CTRL_FETCH = 2'b10;

    // Which requester the memory response of the current cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the data port, fetch port and memory-side signals of the arbiter.
// Optional statistics outputs exist only when MEM_ARB_STATS_EN is defined.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import mem_pkg::*;

    logic              i_d_valid;
    logic              o_d_ready;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    mem_ctrl_t         i_d_ctrl;
    logic              o_d_rsp_valid;
    logic [DATA_W-1:0] o_d_rdata;

    logic              i_i_valid;
    logic              o_i_ready;
    logic [ADDR_W-1:0] i_i_addr;
    logic              o_i_rsp_valid;
    logic [DATA_W-1:0] o_i_rdata;

    logic [ADDR_W-1:0] o_memAddr;
    logic [DATA_W-1:0] o_writeData;
    mem_ctrl_t         o_ctrlMEM;
    logic              o_en_MEM;
    logic [DATA_W-1:0] i_readData;

`ifdef MEM_ARB_STATS_EN
    logic [31:0]       o_stat_dgrants;
    logic [31:0]       o_stat_igrants;
    logic [31:0]       o_stat_conflicts;
`endif

    // Arbiter side.
    modport slave (
        input  i_d_valid, i_d_addr, i_d_wdata, i_d_ctrl,
        input  i_i_valid, i_i_addr, i_readData,
        output o_d_ready, o_d_rsp_valid, o_d_rdata,
        output o_i_ready, o_i_rsp_valid, o_i_rdata,
        output o_memAddr, o_writeData, o_ctrlMEM, o_en_MEM
`ifdef MEM_ARB_STATS_EN
        , output o_stat_dgrants, o_stat_igrants, o_stat_conflicts
`endif
    );

    // Requester / memory side.
    modport master (
        output i_d_valid, i_d_addr, i_d_wdata, i_d_ctrl,
        output i_i_valid, i_i_addr, i_readData,
        input  o_d_ready, o_d_rsp_valid, o_d_rdata,
        input  o_i_ready, o_i_rsp_valid, o_i_rdata,
        input  o_memAddr, o_writeData, o_ctrlMEM, o_en_MEM
`ifdef MEM_ARB_STATS_EN
        , input o_stat_dgrants, o_stat_igrants, o_stat_conflicts
`endif
    );

endinterface

// File: rtl/mem_arb_streak.sv
// Starvation counter: counts consecutive data grants while a fetch waits and
// flags when the fetch must be given the next slot.
module mem_arb_streak #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic d_win,
    input  logic i_win,
    input  logic i_i_valid,
    output logic limit_hit
);
    logic [3:0] streak_reg;

    // Count data grants that bypass a pending fetch; clear once the fetch is served or withdrawn.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            streak_reg <= 4'd0;
        end else if (d_win && i_i_valid) begin
            if (streak_reg != 4'hF)
                streak_reg <= streak_reg + 4'd1;
        end else if (i_win || !i_i_valid) begin
            streak_reg <= 4'd0;
        end
    end

    assign limit_hit = (streak_reg == 4'(MAX_DSTREAK));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port data memory: data stage has
// priority, bounded by a starvation limit so instruction fetch keeps moving.
// Responses return exactly one cycle after their grant.
// Optional build macro: MEM_ARB_STATS_EN adds grant/conflict counters.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    mem_port_arbiter_if.slave bus
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;

    logic       limit_hit;
    logic       d_win;
    logic       i_win;
    arb_owner_t owner_reg;
    logic       d_rd_reg;

    // Data wins unless a fetch has waited out the streak limit; nothing wins during reset.
    assign d_win = !i_reset && bus.i_d_valid && !(bus.i_i_valid && limit_hit);
    assign i_win = !i_reset && bus.i_i_valid && !d_win;

    assign bus.o_d_ready = d_win;
    assign bus.o_i_ready = i_win;

    mem_arb_streak #(.MAX_DSTREAK(MAX_DSTREAK)) u_streak (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .d_win     (d_win),
        .i_win     (i_win),
        .i_i_valid (bus.i_i_valid),
        .limit_hit (limit_hit)
    );

    // Route the winning request to the memory; idle cycles drive all zeros.
    always_comb begin
        bus.o_memAddr   = ZERO_ADDR;
        bus.o_writeData = ZERO_DATA;
        bus.o_ctrlMEM   = 2'b00;
        if (d_win) begin
            bus.o_memAddr   = bus.i_d_addr;
            bus.o_writeData = bus.i_d_wdata;
            bus.o_ctrlMEM   = bus.i_d_ctrl;
        end else if (i_win) begin
            bus.o_memAddr   = bus.i_i_addr;
            bus.o_ctrlMEM   = MEM_CTRL_FETCH;
        end
    end

    assign bus.o_en_MEM = (d_win || i_win) && (bus.o_ctrlMEM != 2'b00);

    // Remember who owns next cycle's memory response, and whether a data grant read.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            owner_reg <= OWN_NONE;
            d_rd_reg  <= 1'b0;
        end else begin
            owner_reg <= d_win ? OWN_D : (i_win ? OWN_I : OWN_NONE);
            d_rd_reg  <= d_win && bus.i_d_ctrl[MEM_RD_BIT];
        end
    end

    // Write and no-op acks carry zero data; only reads forward the memory word.
    assign bus.o_d_rsp_valid = (owner_reg == OWN_D);
    assign bus.o_i_rsp_valid = (owner_reg == OWN_I);
    assign bus.o_d_rdata     = (bus.o_d_rsp_valid && d_rd_reg) ? bus.i_readData : ZERO_DATA;
    assign bus.o_i_rdata     = bus.o_i_rsp_valid ? bus.i_readData : ZERO_DATA;

    // Read+write together is not a legal request; it is served as a read.
    assert property (@(posedge i_clk) disable iff (i_reset)
        !(bus.i_d_valid && bus.i_d_ctrl == 2'b11));

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_dgrants_reg;
    logic [31:0] stat_igrants_reg;
    logic [31:0] stat_conflicts_reg;

    // Free-running wrap-around counters of grants and contention cycles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stat_dgrants_reg   <= 32'd0;
            stat_igrants_reg   <= 32'd0;
            stat_conflicts_reg <= 32'd0;
        end else begin
            stat_dgrants_reg   <= stat_dgrants_reg + 32'(d_win);
            stat_igrants_reg   <= stat_igrants_reg + 32'(i_win);
            stat_conflicts_reg <= stat_conflicts_reg + 32'(bus.i_d_valid && bus.i_i_valid);
        end
    end

    assign bus.o_stat_dgrants   = stat_dgrants_reg;
    assign bus.o_stat_igrants   = stat_igrants_reg;
    assign bus.o_stat_conflicts = stat_conflicts_reg;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the MEM stage (data, read/write) and the IF stage (instruction, read-only).
- Issues at most one memory access per cycle and returns each response exactly one cycle after its grant.
- Data requests have fixed priority, bounded by a starvation limit that guarantees instruction fetch progress.
- Drives the memory's address, write data, ctrlMEM and en_MEM inputs, so the transaction logger attaches directly to its memory-side outputs.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- MAX_DSTREAK, 4, number of consecutive data grants allowed while an instruction request waits; legal range 1..15.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_d_valid  in  1  data request valid.
- o_d_ready  out  1  data request granted this cycle.
- i_d_addr  in  ADDR_W  data request address.
- i_d_wdata  in  DATA_W  data write value.
- i_d_ctrl  in  mem_ctrl_t  [1]=read, [0]=write.
- o_d_rsp_valid  out  1  data response/ack valid.
- o_d_rdata  out  DATA_W  data read result.
- i_i_valid  in  1  instruction fetch request valid.
- o_i_ready  out  1  fetch granted this cycle.
- i_i_addr  in  ADDR_W  fetch address.
- o_i_rsp_valid  out  1  fetch response valid.
- o_i_rdata  out  DATA_W  fetched word.
- o_memAddr  out  ADDR_W  memory address.
- o_writeData  out  DATA_W  memory write data.
- o_ctrlMEM  out  mem_ctrl_t  memory read/write control.
- o_en_MEM  out  1  memory access enable.
- i_readData  in  DATA_W  memory read data, valid the cycle after the access edge.

Behaviour:
Grant (combinational from current inputs and registered state):
- d_win = i_d_valid && !(i_i_valid && streak == MAX_DSTREAK).
- i_win = i_i_valid && !d_win.
- o_d_ready = d_win; o_i_ready = i_win. Never both high.
- A requester holds valid, address and ctrl stable until ready. Ready may be high in the same cycle valid rises (zero-wait grant).

Memory drive:
- On d_win: o_memAddr = i_d_addr, o_writeData = i_d_wdata, o_ctrlMEM = i_d_ctrl.
- On i_win: o_memAddr = i_i_addr, o_writeData = 0, o_ctrlMEM = 2'b10.
- With no grant: all zeros.
- o_en_MEM = (d_win || i_win) && (o_ctrlMEM != 2'b00).

Owner register:
- Owner is arb_owner_t {OWN_NONE, OWN_D, OWN_I}.
- Updated every edge: OWN_D on d_win, OWN_I on i_win, else OWN_NONE.
- o_d_rsp_valid = (owner == OWN_D); o_i_rsp_valid = (owner == OWN_I).
- o_d_rdata and o_i_rdata = i_readData when their rsp_valid is high, else 0.
- Latency is exactly 1 cycle. Back-to-back grants every cycle are allowed; no bubbles.

Data writes and no-op control:
- Writes produce a 1-cycle ack on o_d_rsp_valid; o_d_rdata is 0 for writes.
- A data request with ctrl 2'b00 is granted and acked, with en_MEM low.

Streak counter:
- Saturating counter, width 4.
- d_win while i_i_valid: increment.
- i_win, or no fetch pending: clear to 0.
- d_win while streak == MAX_DSTREAK cannot occur when i_i_valid is high (the fetch wins).

Reset (async, i_reset=1):
- owner = OWN_NONE, streak = 0.
- All rsp_valid outputs 0; all rdata outputs 0.
- The response for a grant made in the cycle before reset is dropped; requesters re-issue.
- Ready/memory outputs stay combinational but are forced to 0 while i_reset is high.

Illegal input:
- i_d_ctrl == 2'b11 is illegal. A simulation assertion fires; the behaviour is the same as for a read.

Optional Feature:
MEM_ARB_STATS_EN:
- When defined, adds outputs o_stat_dgrants, o_stat_igrants and o_stat_conflicts, each 32 bits.
- o_stat_dgrants counts data grants; o_stat_igrants counts fetch grants; o_stat_conflicts counts cycles with both valids high.
- Counters wrap modulo 2^32 and reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg holds:
  - mem_ctrl_t (2-bit packed)
  - MEM_RD_BIT=1 and MEM_WR_BIT=0
  - MEM_CTRL_FETCH=2'b10
  - arb_owner_t
- One natural sub-module: mem_arb_streak, the saturating starvation counter. Inputs: d_win, i_win, i_i_valid. Output: limit_hit.
- Grant, memory drive and response logic stay in the top module.

Test Plan:
1. Data read only: i_d_valid=1, addr 0x100, ctrl 2'b10, memory holds 0xDEADBEEF → o_d_ready=1 same cycle; next cycle o_d_rsp_valid=1, o_d_rdata=0xDEADBEEF, o_i_rsp_valid=0.
2. Simultaneous requests, MAX_DSTREAK=4, both valid held 10 cycles → grant sequence D,D,D,D,I,D,D,D,D,I; each response 1 cycle after its grant; o_en_MEM high every cycle.
3. Data write: addr 0x20, wdata 0x12345678, ctrl 2'b01, then fetch from 0x20 → write ack with rdata 0; fetch returns 0x12345678 two cycles after the write grant.
4. Back-to-back fetches from 0x0, 0x4, 0x8 with i_i_valid held → o_i_ready high 3 consecutive cycles; o_i_rsp_valid high 3 consecutive cycles, one cycle delayed, with the matching words.
5. Reset mid-operation: assert i_reset asynchronously between edges right after a data read grant → o_d_rsp_valid and rdata go 0 immediately and stay 0; streak=0 after release; the next request is granted normally.
6. With MEM_ARB_STATS_EN: scenario 2 → o_stat_dgrants=8, o_stat_igrants=2, o_stat_conflicts=10. Preload o_stat_dgrants to 0xFFFFFFFF via force, then one grant → reads 0.
